lsu_store_buffer: RTL

- Small in-order store FIFO between the MA-stage LSU store path and the data-memory write port.
- Accepts one store per cycle from MA and drains entries to memory under a valid/ready handshake.
- Decouples memory write stalls from the pipeline.
- Optionally forwards buffered store data to MA loads that hit a pending store.

---
 rtl/lsu_store_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: in-order store FIFO between the MA-stage LSU store path
// and the data-memory write port.
//
// Each cycle, MA may push one store into the tail. The head entry drains
// toward memory under a valid/ready handshake. The drain side is
// first-word-fall-through: the head entry is shown combinationally, and it is
// masked to zero while the buffer is empty.
//
// Optional feature: define LSU_STORE_FWD_EN to enable store-to-load
// forwarding. A load whose word address matches a pending store is served
// from the youngest matching entry if that entry has a full strobe. If the
// youngest matching entry has a partial strobe, the load is stalled instead.
// When the macro is undefined, the forwarding outputs are tied to zero and no
// comparators are built.
module lsu_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [AW-1:0]            st_addr,
   input  logic [DW-1:0]            st_data,
   input  logic [DW/8-1:0]          st_strb,
   output logic                     mem_wr_valid,
   input  logic                     mem_wr_ready,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_data,
   output logic [DW/8-1:0]          mem_strb,
   input  logic [AW-1:0]            ld_addr,
   output logic                     ld_hit,
   output logic [DW-1:0]            ld_data,
   output logic                     ld_stall,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = DW / 8;

   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;
   logic [DEPTH-1:0] valid_reg;

   // Entry storage has no reset. Validity is tracked separately, and the
   // drain outputs are masked while the buffer is empty.
   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [SW-1:0] strb_mem [DEPTH];

   logic push;
   logic pop;

   assign empty        = (count_reg == '0);
   assign full         = (count_reg == (PW+1)'(DEPTH));
   assign st_ready     = !full;
   assign mem_wr_valid = !empty;
   assign count        = count_reg;

   // A push is refused when full, even if a pop happens in the same cycle.
   assign push = st_valid && !full;
   assign pop  = mem_wr_valid && mem_wr_ready;

   // FWFT head view, forced to zero while nothing is held.
   assign mem_addr = mem_wr_valid ? addr_mem[rd_ptr_reg] : '0;
   assign mem_data = mem_wr_valid ? data_mem[rd_ptr_reg] : '0;
   assign mem_strb = mem_wr_valid ? strb_mem[rd_ptr_reg] : '0;

   // Write the incoming store into the tail slot.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= st_addr;
         data_mem[wr_ptr_reg] <= st_data;
         strb_mem[wr_ptr_reg] <= st_strb;
      end
   end

   // Update pointers, occupancy and per-entry valid bits. The pointers wrap
   // naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            valid_reg[wr_ptr_reg] <= 1'b1;
         end
         if (pop) begin
            rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            valid_reg[rd_ptr_reg] <= 1'b0;
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

`ifdef LSU_STORE_FWD_EN
   // Per-entry word-address match against the load. The entry popping this
   // cycle is still valid here, so it still takes part in the comparison.
   logic [DEPTH-1:0] match;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] &&
                         (addr_mem[gi][AW-1:2] == ld_addr[AW-1:2]);
   end

   logic          fwd_found;
   logic [PW-1:0] fwd_sel;
   logic [PW-1:0] fwd_idx;

   // Walk the entries from oldest to youngest so the last match wins.
   always_comb begin
      fwd_found = 1'b0;
      fwd_sel   = '0;
      fwd_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr_reg + PW'(k);
         if (match[fwd_idx]) begin
            fwd_found = 1'b1;
            fwd_sel   = fwd_idx;
         end
      end
   end

   // A full-strobe match serves the load; a partial-strobe match stalls it.
   assign ld_hit   = fwd_found && (&strb_mem[fwd_sel]);
   assign ld_stall = fwd_found && !(&strb_mem[fwd_sel]);
   assign ld_data  = ld_hit ? data_mem[fwd_sel] : '0;
`else
   logic unused_ld_addr;
   assign unused_ld_addr = ^ld_addr;

   assign ld_hit   = 1'b0;
   assign ld_stall = 1'b0;
   assign ld_data  = '0;
`endif

endmodule
